inc_reg_bank: RTL and testbench

- Parametrised successor to the processor's increment-select decoder.
- Holds NUM_REGS address/counter registers (ROW, COL, CURR, STA, STB, STC, R1 at default size) inside the block.
- Applies the increment itself: per-register programmable limit, wrap detection, load and clear.
- Sits between the control unit's microcode fields and the datapath; register values drive the datapath directly.

---
 rtl/inc_reg_bank.sv | 95 +++++++++
 tb/tb_inc_reg_bank.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inc_reg_bank.sv
// Bank of NUM_REGS address/counter registers with per-register limit, wrap detect, load and clear.
// Define INC_SAT_EN to saturate at the limit instead of wrapping to zero.
module inc_reg_bank #(
    parameter int unsigned NUM_REGS = 7,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP_W   = 4,
    localparam int unsigned IdxW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inc_en,
    input  logic [NUM_REGS-1:0]       inc_sel,
    input  logic [STEP_W-1:0]         inc_step,
    input  logic                      ld_en,
    input  logic [IdxW-1:0]           ld_idx,
    input  logic                      ld_tgt,
    input  logic [WIDTH-1:0]          ld_data,
    input  logic [NUM_REGS-1:0]       clr_sel,
    output logic [NUM_REGS*WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]       wrap_pulse,
    output logic                      any_wrap
);

    logic [WIDTH-1:0]    val_q [NUM_REGS];
    logic [WIDTH-1:0]    val_d [NUM_REGS];
    logic [WIDTH-1:0]    lim_q [NUM_REGS];
    logic [WIDTH-1:0]    lim_d [NUM_REGS];
    logic [WIDTH:0]      sum   [NUM_REGS];
    logic [NUM_REGS-1:0] ld_hit;
    logic [NUM_REGS-1:0] wrap_d;
    logic [NUM_REGS-1:0] wrap_q;
    logic                any_wrap_q;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            // Out-of-range ld_idx matches no register, so invalid loads fall away here.
            ld_hit[i] = ld_en && (ld_idx == IdxW'(i));
            sum[i]    = {1'b0, val_q[i]} + (WIDTH + 1)'(inc_step);
            val_d[i]  = val_q[i];
            lim_d[i]  = lim_q[i];
            wrap_d[i] = 1'b0;
            if (clr_sel[i]) begin
                val_d[i] = '0;
            end else if (ld_hit[i] && !ld_tgt) begin
                val_d[i] = ld_data;
            end else begin
                // A limit load coexists with an increment, which still sees the old limit.
                if (ld_hit[i] && ld_tgt) begin
                    lim_d[i] = ld_data;
                end
                if (inc_en && inc_sel[i]) begin
                    if (sum[i] > {1'b0, lim_q[i]}) begin
`ifdef INC_SAT_EN
                        val_d[i] = lim_q[i];
`else
                        val_d[i] = '0;
`endif
                        wrap_d[i] = 1'b1;
                    end else begin
                        val_d[i] = sum[i][WIDTH-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                val_q[i] <= '0;
                lim_q[i] <= '1;
            end
            wrap_q     <= '0;
            any_wrap_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                val_q[i] <= val_d[i];
                lim_q[i] <= lim_d[i];
            end
            wrap_q     <= wrap_d;
            any_wrap_q <= |wrap_d;
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*WIDTH +: WIDTH] = val_q[i];
        end
    end

    assign wrap_pulse = wrap_q;
    assign any_wrap   = any_wrap_q;

endmodule

// File: tb/tb_inc_reg_bank.sv
// Scoreboard bench for inc_reg_bank at default size; follows INC_SAT_EN when defined.
module tb_inc_reg_bank;

    localparam int N = 7;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           inc_en;
    logic [N-1:0]   inc_sel;
    logic [3:0]     inc_step;
    logic           ld_en;
    logic [2:0]     ld_idx;
    logic           ld_tgt;
    logic [W-1:0]   ld_data;
    logic [N-1:0]   clr_sel;
    logic [N*W-1:0] reg_out;
    logic [N-1:0]   wrap_pulse;
    logic           any_wrap;

    typedef struct packed {
        logic [N*W-1:0] o;
        logic [N-1:0]   w;
        logic           a;
    } exp_t;

    exp_t sb_q[$];
    int   mval [N];
    int   mlim [N];
    int   n_cmp = 0;
    int   n_err = 0;

    inc_reg_bank dut (
        .clk        (clk),
        .rst        (rst),
        .inc_en     (inc_en),
        .inc_sel    (inc_sel),
        .inc_step   (inc_step),
        .ld_en      (ld_en),
        .ld_idx     (ld_idx),
        .ld_tgt     (ld_tgt),
        .ld_data    (ld_data),
        .clr_sel    (clr_sel),
        .reg_out    (reg_out),
        .wrap_pulse (wrap_pulse),
        .any_wrap   (any_wrap)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] reg_at(input int i);
        return reg_out[i*W +: W];
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; inc_en = 1'b0; inc_sel = '0; inc_step = '0;
        ld_en = 1'b0; ld_idx = '0; ld_tgt = 1'b0; ld_data = '0; clr_sel = '0;
    endtask

    // Advance the model with the currently driven inputs, then compare after the edge.
    task automatic tick(input string tag);
        exp_t e;
        int   s;
        int   nl;
        bit   hit;
        e = '0;
        for (int i = 0; i < N; i++) begin
            hit = ld_en && (int'(ld_idx) == i);
            nl  = mlim[i];
            if (rst) begin
                mval[i] = 0;
                nl      = 255;
            end else if (clr_sel[i]) begin
                mval[i] = 0;
            end else if (hit && !ld_tgt) begin
                mval[i] = int'(ld_data);
            end else begin
                if (hit && ld_tgt) nl = int'(ld_data);
                if (inc_en && inc_sel[i]) begin
                    s = mval[i] + int'(inc_step);
                    if (s > mlim[i]) begin
`ifdef INC_SAT_EN
                        mval[i] = mlim[i];
`else
                        mval[i] = 0;
`endif
                        e.w[i] = 1'b1;
                    end else begin
                        mval[i] = s;
                    end
                end
            end
            mlim[i] = nl;
            e.o[i*W +: W] = W'(mval[i]);
        end
        e.a = |e.w;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, "_out"}, 64'(reg_out), 64'(e.o));
            check_val({tag, "_wrap"}, 64'(wrap_pulse), 64'(e.w));
            check_val({tag, "_any"}, 64'(any_wrap), 64'(e.a));
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mval[i] = 0;
            mlim[i] = 0;
        end
        idle_inputs();
        rst = 1'b1;
        tick("init_rst");

        // Random traffic, then reset asserted with random inputs still driven.
        for (int k = 0; k < 20; k++) begin
            inc_en = 1'($urandom); inc_sel = N'($urandom); inc_step = 4'($urandom);
            ld_en = 1'($urandom); ld_idx = 3'($urandom); ld_tgt = 1'($urandom);
            ld_data = W'($urandom); clr_sel = N'($urandom_range(0, 3));
            tick("rand");
        end
        inc_en = 1'b1; inc_sel = '1; inc_step = 4'hf; ld_en = 1'b1; ld_data = 8'h55;
        clr_sel = 7'h11; rst = 1'b1;
        tick("mid_rst");
        check_val("rst_regs", 64'(reg_out), 64'd0);
        check_val("rst_wrap", 64'(wrap_pulse), 64'd0);

        // Reset limit is 0xFF: 255 increments reach 255 without wrapping.
        for (int k = 0; k < 255; k++) begin
            inc_en = 1'b1; inc_sel = 7'b0000001; inc_step = 4'd1;
            tick("lim_ff");
        end
        check_val("r0_at_255", 64'(reg_at(0)), 64'd255);
        check_val("r0_no_wrap", 64'(wrap_pulse[0]), 64'd0);
        inc_en = 1'b1; inc_sel = 7'b0000001; inc_step = 4'd1;
        tick("lim_ff_wrap");
`ifdef INC_SAT_EN
        check_val("r0_after_256", 64'(reg_at(0)), 64'd255);
`else
        check_val("r0_after_256", 64'(reg_at(0)), 64'd0);
`endif
        check_val("r0_wrap_256", 64'(wrap_pulse[0]), 64'd1);

        rst = 1'b1;
        tick("rst2");
        for (int k = 0; k < 2; k++) begin
            inc_en = 1'b1; inc_sel = 7'b1010101; inc_step = 4'd3;
            tick("multi");
        end
        check_val("multi_r0", 64'(reg_at(0)), 64'd6);
        check_val("multi_r1", 64'(reg_at(1)), 64'd0);
        check_val("multi_r6", 64'(reg_at(6)), 64'd6);

        // Limit wrap on CURR.
        ld_en = 1'b1; ld_idx = 3'd2; ld_tgt = 1'b1; ld_data = 8'd10;
        tick("ld_lim2");
        ld_en = 1'b1; ld_idx = 3'd2; ld_tgt = 1'b0; ld_data = 8'd8;
        tick("ld_val2");
        inc_en = 1'b1; inc_sel = 7'b0000100; inc_step = 4'd2;
        tick("inc2a");
        check_val("r2_at_lim", 64'(reg_at(2)), 64'd10);
        check_val("r2_no_wrap", 64'(wrap_pulse[2]), 64'd0);
        inc_en = 1'b1; inc_sel = 7'b0000100; inc_step = 4'd2;
        tick("inc2b");
`ifdef INC_SAT_EN
        check_val("r2_over", 64'(reg_at(2)), 64'd10);
`else
        check_val("r2_over", 64'(reg_at(2)), 64'd0);
`endif
        check_val("r2_wrap", 64'(wrap_pulse[2]), 64'd1);
        check_val("r2_any", 64'(any_wrap), 64'd1);
        tick("idle_after_wrap");
        check_val("r2_pulse_gone", 64'(any_wrap), 64'd0);

        // Priority: clear beats load beats increment.
        clr_sel = 7'b0000010; ld_en = 1'b1; ld_idx = 3'd1; ld_data = 8'd50;
        inc_en = 1'b1; inc_sel = 7'b0000010; inc_step = 4'd1;
        tick("prio_clr");
        check_val("prio_r1_clr", 64'(reg_at(1)), 64'd0);
        ld_en = 1'b1; ld_idx = 3'd1; ld_data = 8'd50;
        inc_en = 1'b1; inc_sel = 7'b0000010; inc_step = 4'd1;
        tick("prio_ld");
        check_val("prio_r1_ld", 64'(reg_at(1)), 64'd50);
        check_val("prio_no_wrap", 64'(wrap_pulse), 64'd0);

        // Limit load same edge as increment: increment uses the old limit (255).
        ld_en = 1'b1; ld_idx = 3'd1; ld_tgt = 1'b1; ld_data = 8'd52;
        inc_en = 1'b1; inc_sel = 7'b0000010; inc_step = 4'd5;
        tick("lim_and_inc");
        check_val("r1_old_lim", 64'(reg_at(1)), 64'd55);

        // Sum carried into bit WIDTH must not be truncated.
        ld_en = 1'b1; ld_idx = 3'd6; ld_data = 8'd250;
        tick("ld_r6");
        inc_en = 1'b1; inc_sel = 7'b1000000; inc_step = 4'd15;
        tick("r6_carry");
`ifdef INC_SAT_EN
        check_val("r6_carry_val", 64'(reg_at(6)), 64'd255);
`else
        check_val("r6_carry_val", 64'(reg_at(6)), 64'd0);
`endif
        check_val("r6_carry_wrap", 64'(wrap_pulse[6]), 64'd1);

        // Value above limit wraps even with a zero step.
        ld_en = 1'b1; ld_idx = 3'd5; ld_tgt = 1'b1; ld_data = 8'd100;
        tick("ld_lim5");
        ld_en = 1'b1; ld_idx = 3'd5; ld_data = 8'd200;
        tick("ld_val5");
        inc_en = 1'b1; inc_sel = 7'b0100000; inc_step = 4'd0;
        tick("r5_step0");
`ifdef INC_SAT_EN
        check_val("r5_step0_val", 64'(reg_at(5)), 64'd100);
`else
        check_val("r5_step0_val", 64'(reg_at(5)), 64'd0);
`endif
        check_val("r5_step0_wrap", 64'(wrap_pulse[5]), 64'd1);

        // Invalid index and disabled increment leave state alone.
        ld_en = 1'b1; ld_idx = 3'd7; ld_data = 8'd77;
        tick("bad_idx_val");
        ld_en = 1'b1; ld_idx = 3'd7; ld_tgt = 1'b1; ld_data = 8'd1;
        tick("bad_idx_lim");
        inc_en = 1'b0; inc_sel = '1; inc_step = 4'd9;
        tick("inc_dis");
        check_val("dis_r1", 64'(reg_at(1)), 64'd55);
        check_val("dis_wrap", 64'(wrap_pulse), 64'd0);
        // Limits untouched: another increment of everything follows the model.
        inc_en = 1'b1; inc_sel = '1; inc_step = 4'd9;
        tick("post_dis_inc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
